cp_sym_sched: RTL and testbench

- Cyclic-prefix insertion scheduler for the OFDM transmit path.
- Sits between the IFFT output and the spectrum-reversal stage.
- Buffers each N_FFT-sample symbol in a two-bank ping-pong RAM, then plays it out as a CP_LEN-sample prefix followed by the full body.
- Drives out_sop and a phase-realign pulse, rev_rst, so the downstream ±1 alternation restarts at the same phase on every symbol.

---
 rtl/cp_pkg.sv | 16 +
 rtl/cp_sym_sched_if.sv | 25 ++
 rtl/cp_pp_ram.sv | 31 +++
 rtl/cp_sym_sched.sv | 179 +++++++++++++++++
 tb/tb_cp_sym_sched.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp_pkg.sv
// Shared types and default sizing for the cyclic-prefix insertion scheduler.
package cp_pkg;

  localparam int N_FFT_DEF  = 64;
  localparam int CP_LEN_DEF = 16;
  localparam int DW_DEF     = 20;
  localparam int AW         = $clog2(N_FFT_DEF);

  typedef enum logic [1:0] {IDLE, PREFIX, BODY} rd_state_e;

  typedef struct packed {
    logic signed [DW_DEF-1:0] i;
    logic signed [DW_DEF-1:0] q;
  } sample_t;

endpackage

// File: rtl/cp_sym_sched_if.sv
// Stream bundle of the scheduler: IFFT samples in, prefixed symbols out.
interface cp_sym_sched_if #(parameter int DW = cp_pkg::DW_DEF);

  logic                 in_valid;
  logic                 in_sop;
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_sop;
  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;
  logic                 rev_rst;

  modport slave (
    input  in_valid, in_sop, in_i, in_q,
    output in_ready, out_valid, out_sop, out_i, out_q, rev_rst
  );

  modport master (
    output in_valid, in_sop, in_i, in_q,
    input  in_ready, out_valid, out_sop, out_i, out_q, rev_rst
  );

endinterface

// File: rtl/cp_pp_ram.sv
// Two-bank ping-pong sample store, addressed by {bank, addr}, with a registered read port.
module cp_pp_ram #(
  parameter int AW = cp_pkg::AW,
  parameter int W  = 2 * cp_pkg::DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW:0]   i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [2**(AW+1)];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // The read register doubles as the output sample register, so it clears on reset.
  always_ff @(posedge clk) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cp_sym_sched.sv
// Cyclic-prefix insertion scheduler: buffers symbols in a ping-pong RAM and plays out prefix + body.
// Optional status outputs (ovf_sticky, runt_sticky, sym_cnt) are enabled by CP_SCHED_STATUS_EN.
module cp_sym_sched
  import cp_pkg::*;
#(
  parameter int N_FFT  = N_FFT_DEF,
  parameter int CP_LEN = CP_LEN_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  cp_sym_sched_if.slave    bus
`ifdef CP_SCHED_STATUS_EN
  ,
  output logic             ovf_sticky,
  output logic             runt_sticky,
  output logic [15:0]      sym_cnt
`endif
);

  localparam int LAW = $clog2(N_FFT);
  localparam logic [LAW-1:0] LAST = LAW'(N_FFT - 1);
  localparam logic [LAW-1:0] PRE  = LAW'(N_FFT - CP_LEN);

  logic [1:0]      r_full;
  logic            r_wbank;
  logic            r_rbank;
  logic [LAW-1:0]  r_waddr;
  logic [LAW-1:0]  r_raddr;
  rd_state_e       r_state;
  logic            r_out_valid;
  logic            r_out_sop;

  logic            w_ready;
  logic            w_accept;
  logic [LAW-1:0]  w_wr_addr;
  logic            w_wr_last;
  logic            w_rd_en;
  logic            w_rd_last;
  logic [1:0]      w_full_nxt;
  rd_state_e       w_state_nxt;
  logic [LAW-1:0]  w_raddr_nxt;
  logic            w_rbank_nxt;
  logic [2*DW-1:0] w_rdata;

  assign w_ready   = en & ~r_full[r_wbank];
  assign w_accept  = bus.in_valid & w_ready;
  assign w_wr_addr = bus.in_sop ? '0 : r_waddr;
  assign w_wr_last = w_accept && (w_wr_addr == LAST);
  assign w_rd_en   = en && (r_state != IDLE);
  assign w_rd_last = w_rd_en && (r_state == BODY) && (r_raddr == LAST);

  // Writer and reader always own different banks, so set and clear never collide.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wbank] = 1'b1;
    if (w_rd_last) w_full_nxt[r_rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full  <= '0;
      r_wbank <= 1'b0;
      r_waddr <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        if (w_wr_last) begin
          r_waddr <= '0;
          r_wbank <= ~r_wbank;
        end else begin
          r_waddr <= w_wr_addr + LAW'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_raddr_nxt = r_raddr;
    w_rbank_nxt = r_rbank;
    case (r_state)
      IDLE: begin
        if (r_full[r_rbank]) begin
          w_state_nxt = PREFIX;
          w_raddr_nxt = PRE;
        end
      end
      PREFIX: begin
        if (r_raddr == LAST) begin
          w_state_nxt = BODY;
          w_raddr_nxt = '0;
        end else begin
          w_raddr_nxt = r_raddr + LAW'(1);
        end
      end
      BODY: begin
        if (r_raddr == LAST) begin
          w_rbank_nxt = ~r_rbank;
          if (r_full[~r_rbank]) begin
            w_state_nxt = PREFIX;
            w_raddr_nxt = PRE;
          end else begin
            w_state_nxt = IDLE;
            w_raddr_nxt = '0;
          end
        end else begin
          w_raddr_nxt = r_raddr + LAW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_raddr <= '0;
      r_rbank <= 1'b0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_raddr <= w_raddr_nxt;
      r_rbank <= w_rbank_nxt;
    end
  end

  // Strobes track the read enable, which already drops them on any disabled edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
    end else begin
      r_out_valid <= w_rd_en;
      r_out_sop   <= w_rd_en && (r_state == PREFIX) && (r_raddr == PRE);
    end
  end

  cp_pp_ram #(.AW(LAW), .W(2 * DW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept),
    .i_waddr ({r_wbank, w_wr_addr}),
    .i_wdata ({bus.in_i, bus.in_q}),
    .i_re    (w_rd_en),
    .i_raddr ({r_rbank, r_raddr}),
    .o_rdata (w_rdata)
  );

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sop   = r_out_sop;
  assign bus.rev_rst   = r_out_sop;
  assign bus.out_i     = w_rdata[2*DW-1:DW];
  assign bus.out_q     = w_rdata[DW-1:0];

`ifdef CP_SCHED_STATUS_EN
  logic        r_ovf;
  logic        r_runt;
  logic [15:0] r_sym_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf     <= 1'b0;
      r_runt    <= 1'b0;
      r_sym_cnt <= '0;
    end else if (en) begin
      if (bus.in_valid && !w_ready) r_ovf <= 1'b1;
      if (w_accept && bus.in_sop && (r_waddr != '0)) r_runt <= 1'b1;
      if (w_rd_last) r_sym_cnt <= r_sym_cnt + 16'd1;
    end
  end

  assign ovf_sticky  = r_ovf;
  assign runt_sticky = r_runt;
  assign sym_cnt     = r_sym_cnt;
`endif

endmodule

// File: tb/tb_cp_sym_sched.sv
// Randomised self-checking bench for cp_sym_sched against a queue-based symbol model.
module tb_cp_sym_sched;
  import cp_pkg::*;

  localparam int N  = 64;
  localparam int CP = 16;
  localparam int DW = DW_DEF;

  logic clk, rst_n, en;
  cp_sym_sched_if #(.DW(DW)) bus();
`ifdef CP_SCHED_STATUS_EN
  logic        ovf_sticky, runt_sticky;
  logic [15:0] sym_cnt;
`endif

  cp_sym_sched #(.N_FFT(N), .CP_LEN(CP), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
`ifdef CP_SCHED_STATUS_EN
    ,
    .ovf_sticky  (ovf_sticky),
    .runt_sticky (runt_sticky),
    .sym_cnt     (sym_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: actual %0d expected %0d", name, actual, expected);
  endtask

  // Model: completed symbols queue up in arrival order; each is emitted as its last CP samples then all N.
  sample_t m_symq[$];
  sample_t m_part[N];
  int      m_cnt, m_nfull, m_pos, m_done, cyc, t_wlast, nb;
  bit      m_run, m_ovf, m_runt, rlast, wlast;
  bit      e_valid, e_sop;
  sample_t e_s;

  initial cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_symq.delete();
      m_cnt = 0; m_nfull = 0; m_pos = 0; m_done = 0;
      m_run = 0; m_ovf = 0; m_runt = 0;
      e_valid = 0; e_sop = 0; e_s = '0;
    end else if (!en) begin
      e_valid = 0; e_sop = 0;
    end else begin
      nb = m_nfull; rlast = 0; wlast = 0;
      e_valid = 0; e_sop = 0;
      if (!m_run) begin
        if (nb > 0) begin m_run = 1; m_pos = 0; end
      end else begin
        e_valid = 1;
        e_sop   = (m_pos == 0);
        e_s     = (m_pos < CP) ? m_symq[N - CP + m_pos] : m_symq[m_pos - CP];
        m_pos++;
        if (m_pos == N + CP) begin
          repeat (N) void'(m_symq.pop_front());
          rlast = 1; m_done++; m_pos = 0;
          m_run = (nb == 2);
        end
      end
      if (bus.in_valid && nb >= 2) m_ovf = 1;
      if (bus.in_valid && nb < 2) begin
        if (bus.in_sop) begin
          if (m_cnt != 0) m_runt = 1;
          m_cnt = 0;
        end
        m_part[m_cnt] = {bus.in_i, bus.in_q};
        m_cnt++;
        if (m_cnt == N) begin
          for (int k = 0; k < N; k++) m_symq.push_back(m_part[k]);
          wlast = 1; m_cnt = 0; t_wlast = cyc;
        end
      end
      m_nfull = nb + int'(wlast) - int'(rlast);
    end
  end

  bit cmp_on = 0;
  bit seen_busy;
  int obs_i[$];
  int obs_t[$];
  int obs_sop;

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("out_valid", bus.out_valid, e_valid);
      checkOutput("out_sop", bus.out_sop, e_sop);
      checkOutput("rev_rst", bus.rev_rst, e_sop);
      checkOutput("in_ready", bus.in_ready, en && (m_nfull < 2));
      if (e_valid) begin
        checkOutput("out_i", bus.out_i, e_s.i);
        checkOutput("out_q", bus.out_q, e_s.q);
      end
      if (bus.out_valid) begin
        obs_i.push_back(int'(bus.out_i));
        obs_t.push_back(cyc);
        if (bus.out_sop) obs_sop++;
      end
      if (en && !bus.in_ready) seen_busy = 1;
    end
  end

  task automatic applyStimulus(input bit sop, input int iv);
    int budget = 400;
    while (!(en && m_nfull < 2) && budget > 0) begin
      bus.in_valid = 0;
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) checkOutput("ready_timeout", 0, 1);
    bus.in_valid = 1;
    bus.in_sop   = sop;
    bus.in_i     = DW'(iv);
    bus.in_q     = DW'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic sendRamp(input int base);
    for (int k = 0; k < N; k++) applyStimulus(k == 0, base + k);
    bus.in_valid = 0;
    bus.in_sop   = 0;
  endtask

  task automatic waitIdle();
    int budget = 2000;
    while ((m_run || m_nfull != 0) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) checkOutput("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic waitObs(input int n);
    int budget = 500;
    while (obs_i.size() < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) checkOutput("obs_timeout", 0, 1);
  endtask

  task automatic doReset();
    rst_n = 0;
    bus.in_valid = 0;
    bus.in_sop   = 0;
    @(posedge clk); #1;
    rst_n = 1;
    obs_i.delete(); obs_t.delete(); obs_sop = 0; seen_busy = 0;
  endtask

  function automatic int rampErrors(input int base, input int start);
    int errs = 0;
    for (int k = 0; k < N + CP; k++) begin
      int exp_i = base + ((k < CP) ? (N - CP + k) : (k - CP));
      if (start + k >= obs_i.size()) errs++;
      else if (obs_i[start + k] != exp_i) errs++;
    end
    return errs;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dropped, hits, budget;
    rst_n = 0; en = 1;
    bus.in_valid = 0; bus.in_sop = 0; bus.in_i = '0; bus.in_q = '0;
    obs_sop = 0; seen_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp_on = 1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_i", bus.out_i, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);
    rst_n = 1;

    $display("[TB] single symbol ramp");
    sendRamp(0);
    waitIdle();
    checkOutput("t1_count", obs_i.size(), 80);
    checkOutput("t1_ramp_errors", rampErrors(0, 0), 0);
    checkOutput("t1_first_i", obs_i[0], 48);
    checkOutput("t1_body_start_i", obs_i[16], 0);
    checkOutput("t1_last_i", obs_i[79], 63);
    checkOutput("t1_sop_count", obs_sop, 1);
    checkOutput("t1_latency", obs_t[0] - t_wlast, 2);
    checkOutput("t1_span", obs_t[79] - obs_t[0], 79);

    $display("[TB] continuous four symbols");
    doReset();
    for (int s = 0; s < 4; s++) sendRamp(1000 * (s + 1));
    waitIdle();
    checkOutput("t2_count", obs_i.size(), 320);
    checkOutput("t2_span", obs_t[319] - obs_t[0], 319);
    checkOutput("t2_sop_count", obs_sop, 4);
    checkOutput("t2_ready_throttled", seen_busy, 1);
    checkOutput("t2_sym3_errors", rampErrors(4000, 240), 0);
`ifdef CP_SCHED_STATUS_EN
    checkOutput("t2_ovf_sticky", ovf_sticky, 0);
    checkOutput("t2_sym_cnt", sym_cnt, 4);
`endif

    $display("[TB] runt symbol");
    doReset();
    applyStimulus(1, 500);
    for (int k = 1; k < 20; k++) applyStimulus(0, 500 + k);
    sendRamp(100);
    waitIdle();
    checkOutput("t3_count", obs_i.size(), 80);
    checkOutput("t3_ramp_errors", rampErrors(100, 0), 0);
    checkOutput("t3_first_i", obs_i[0], 148);
    checkOutput("t3_sop_count", obs_sop, 1);
`ifdef CP_SCHED_STATUS_EN
    checkOutput("t3_runt_sticky", runt_sticky, 1);
`endif

    $display("[TB] enable stall in prefix");
    doReset();
    sendRamp(300);
    waitObs(5);
    en = 0;
    repeat (3) @(posedge clk);
    #1;
    en = 1;
    waitIdle();
    checkOutput("t4_count", obs_i.size(), 80);
    checkOutput("t4_ramp_errors", rampErrors(300, 0), 0);
    checkOutput("t4_sop_count", obs_sop, 1);
    checkOutput("t4_span", obs_t[79] - obs_t[0], 82);

    $display("[TB] reset mid body");
    doReset();
    sendRamp(400);
    waitObs(40);
    rst_n = 0;
    @(posedge clk); #1;
    checkOutput("t5_out_valid", bus.out_valid, 0);
    checkOutput("t5_out_sop", bus.out_sop, 0);
    checkOutput("t5_rev_rst", bus.rev_rst, 0);
    checkOutput("t5_out_i", bus.out_i, 0);
    checkOutput("t5_out_q", bus.out_q, 0);
    checkOutput("t5_in_ready", bus.in_ready, 1);
    rst_n = 1;
    obs_i.delete(); obs_t.delete(); obs_sop = 0;
    sendRamp(600);
    waitIdle();
    checkOutput("t5_count", obs_i.size(), 80);
    checkOutput("t5_ramp_errors", rampErrors(600, 0), 0);

    $display("[TB] overflow while both banks full");
    doReset();
    sendRamp(700);
    sendRamp(800);
    budget = 200;
    while (m_nfull != 2 && budget > 0) begin @(posedge clk); #1; budget--; end
    dropped = 0;
    while (m_nfull == 2 && dropped < 3) begin
      bus.in_valid = 1; bus.in_sop = 0; bus.in_i = DW'(20'h7FFFF);
      @(posedge clk); #1;
      dropped++;
    end
    bus.in_valid = 0;
    checkOutput("t6_dropped", dropped, 3);
    waitIdle();
    hits = 0;
    foreach (obs_i[k]) if (obs_i[k] == 524287) hits++;
    checkOutput("t6_count", obs_i.size(), 160);
    checkOutput("t6_forbidden_hits", hits, 0);
    checkOutput("t6_sym0_errors", rampErrors(700, 0), 0);
    checkOutput("t6_sym1_errors", rampErrors(800, 80), 0);
`ifdef CP_SCHED_STATUS_EN
    checkOutput("t6_ovf_sticky", ovf_sticky, 1);
`endif

    $display("[TB] randomised traffic");
    doReset();
    repeat (1500) begin
      en           = ($urandom_range(0, 7) != 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_sop   = ($urandom_range(0, 99) == 0);
      bus.in_i     = DW'($urandom);
      bus.in_q     = DW'($urandom);
      @(posedge clk); #1;
    end
    en = 1; bus.in_valid = 0; bus.in_sop = 0;
    waitIdle();
    checkOutput("t7_symbols_seen", obs_sop > 3, 1);
`ifdef CP_SCHED_STATUS_EN
    checkOutput("t7_ovf_sticky", ovf_sticky, m_ovf);
    checkOutput("t7_runt_sticky", runt_sticky, m_runt);
    checkOutput("t7_sym_cnt", sym_cnt, m_done % 65536);
`endif

    cmp_on = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
